// File: rtl/clk_sel_ctrl.sv
// Sequencer for the div2/4/8/16 clock selector: gates the output clock, swaps the select
// while gated, and ungates on the phase boundary shared by every divided clock.
`timescale 1ns/1ps
module clk_sel_ctrl #(
  parameter int unsigned GATE_CYCLES = 2,
  parameter logic [1:0]  RESET_SEL   = 2'b00
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       req_valid_i,
  input  logic [1:0] req_sel_i,
  output logic       req_ready_o,
  input  logic       lock_i,
  output logic [1:0] sel_out_o,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [3:0] HoldLast = 4'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitOff, StGated, StWaitOn} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] hold_q, hold_d;
  logic [1:0] tgt_q, tgt_d;
  logic [1:0] sel_q, sel_d;
  logic       clk_en_q, clk_en_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       bnd;

  // Mirrors the divider chain phase; cnt == 15 is the common rising boundary.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_q + 4'h1;
    end
  end

  assign bnd = (cnt_q == 4'hF);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= StIdle;
      hold_q   <= 4'h0;
      tgt_q    <= RESET_SEL;
      sel_q    <= RESET_SEL;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tgt_q    <= tgt_d;
      sel_q    <= sel_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tgt_d    = tgt_q;
    sel_d    = sel_q;
    clk_en_d = clk_en_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (lock_i) begin
            err_d = 1'b1;
          end else if (req_sel_i == sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = req_sel_i;
            state_d = StWaitOff;
          end
        end
      end
      StWaitOff: begin
        if (bnd) begin
          clk_en_d = 1'b0;
          hold_d   = 4'h0;
          state_d  = StGated;
        end
      end
      StGated: begin
        hold_d = hold_q + 4'h1;
        if (hold_q == HoldLast) begin
          sel_d   = tgt_q;
          state_d = StWaitOn;
        end
      end
      StWaitOn: begin
        if (bnd) begin
          clk_en_d = 1'b1;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = ~req_ready_o;
  assign sel_out_o   = sel_q;
  assign clk_en_o    = clk_en_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifndef SYNTHESIS
  a_done_err_excl: assert property (@(posedge pclk) disable iff (!presetn) !(done_o && err_o));
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: stimulus pushes timestamped expected events, a negedge monitor
// observes sel/clk_en changes and done/err pulses and pops them in order.
`timescale 1ns/1ps
module tb_clk_sel_ctrl;

  localparam int unsigned G = 2;
  localparam logic [1:0] KSel = 2'd0, KEn = 2'd1, KDone = 2'd2, KErr = 2'd3;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic       lock = 1'b0;
  logic       req_ready, clk_en, busy, done, err;
  logic [1:0] sel_out;

  clk_sel_ctrl #(.GATE_CYCLES(G), .RESET_SEL(2'b00)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .req_valid_i(req_valid),
    .req_sel_i  (req_sel),
    .req_ready_o(req_ready),
    .lock_i     (lock),
    .sel_out_o  (sel_out),
    .clk_en_o   (clk_en),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 pclk = ~pclk;

  // Edges since reset release; equals the DUT phase counter modulo 16.
  int unsigned cyc;
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  val;
    logic [31:0] stamp;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [1:0]  model_sel;
  int unsigned idle_at;
  logic [1:0]  prev_sel;
  logic        prev_en;

  function automatic void push(input logic [1:0] kind, input logic [1:0] val,
                               input int unsigned stamp);
    ev_t e;
    e.kind  = kind;
    e.val   = val;
    e.stamp = stamp;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, expv, cyc);
    end
  endtask

  task automatic observe(input logic [1:0] kind, input logic [1:0] val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: kind=%0d val=%0d at cyc=%0d, nothing expected",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.stamp != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.stamp);
      end
    end
  endtask

  // Monitor: fixed order per cycle is sel change, clk_en change, done, err.
  always @(negedge pclk) begin
    if (!presetn) begin
      prev_sel = sel_out;
      prev_en  = clk_en;
    end else begin
      if (sel_out !== prev_sel) observe(KSel, sel_out);
      if (clk_en !== prev_en)   observe(KEn, {1'b0, clk_en});
      if (done === 1'b1)        observe(KDone, 2'b00);
      if (err === 1'b1)         observe(KErr, 2'b00);
      prev_sel = sel_out;
      prev_en  = clk_en;
    end
  end

  task automatic wait_until(input int unsigned t);
    int n = 0;
    while (cyc < t && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    if (cyc != t) begin
      total++;
      bad++;
      $display("FAIL wait_until: cyc=%0d target=%0d", cyc, t);
    end
  endtask

  // Called at a negedge; holds the request until the model's acceptance edge.
  task automatic issue(input logic [1:0] sel, input logic lk, output int unsigned acc);
    int unsigned e;
    acc = ((cyc > idle_at) ? cyc : idle_at) + 1;
    req_valid = 1'b1;
    req_sel   = sel;
    lock      = lk;
    if (lk) begin
      push(KErr, 2'b00, acc);
      idle_at = acc;
    end else if (sel == model_sel) begin
      push(KDone, 2'b00, acc);
      idle_at = acc;
    end else begin
      e = (acc / 16 + 1) * 16;
      push(KEn, 2'b00, e);
      push(KSel, sel, e + G);
      push(KEn, 2'b01, e + 16);
      push(KDone, 2'b00, e + 16);
      idle_at   = e + 16;
      model_sel = sel;
    end
    wait_until(acc - 1);
    check("ready_at_accept", {31'b0, req_ready}, 32'd1);
    wait_until(acc);
    req_valid = 1'b0;
    lock      = 1'b0;
  endtask

  initial begin
    int unsigned acc;
    int unsigned t;
    model_sel = 2'b00;
    idle_at   = 0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;

    // Reset release and idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (i % 5 == 4) begin
        check("idle_sel", {30'b0, sel_out}, 32'd0);
        check("idle_clk_en", {31'b0, clk_en}, 32'd1);
        check("idle_ready", {31'b0, req_ready}, 32'd1);
        check("idle_busy", {31'b0, busy}, 32'd0);
      end
    end

    // 00 -> 10 accepted at cnt=3; lock and req_sel wiggle while in flight.
    wait_until(35);
    issue(2'b10, 1'b0, acc);
    lock    = 1'b1;
    req_sel = 2'b01;
    wait_until(40);
    check("busy_inflight", {31'b0, busy}, 32'd1);
    lock = 1'b0;
    wait_until(idle_at);
    check("sw1_sel", {30'b0, sel_out}, 32'h2);
    check("sw1_clk_en", {31'b0, clk_en}, 32'd1);

    // No-op request.
    issue(2'b10, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      check("noop_busy", {31'b0, busy}, 32'd0);
      check("noop_clk_en", {31'b0, clk_en}, 32'd1);
      @(negedge pclk);
    end

    // Locked request rejected, then retry accepted on a boundary edge.
    issue(2'b11, 1'b1, acc);
    @(negedge pclk);
    check("lock_sel_kept", {30'b0, sel_out}, {30'b0, model_sel});
    t = (cyc / 16) * 16 + 15;
    if (t < cyc) t += 16;
    wait_until(t);
    issue(2'b11, 1'b0, acc);
    wait_until(idle_at);
    check("sw2_sel", {30'b0, sel_out}, 32'h3);

    // Reset while gated.
    issue(2'b01, 1'b0, acc);
    wait_until((acc / 16 + 1) * 16);
    #2 presetn = 1'b0;
    #1;
    check("rst_clk_en", {31'b0, clk_en}, 32'd1);
    check("rst_sel", {30'b0, sel_out}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    model_sel = 2'b00;
    idle_at   = 0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;

    // Back-to-back requests: second held through the first switch.
    wait_until(2);
    issue(2'b01, 1'b0, acc);
    issue(2'b11, 1'b0, acc);
    wait_until(idle_at + 3);
    check("final_sel", {30'b0, sel_out}, 32'h3);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
